// File: rtl/ann_pkg.sv
// Shared types and helpers for the time-multiplexed classifier layer.
//   - state_e : sequencer FSM states
//   - DefDw / DefAccW : default feature/weight and accumulator widths
//   - DigitW : width of the predicted-digit index (up to 16 output neurons)
//   - sat_add : signed add clipped to a w-bit signed range
package ann_pkg;

    localparam int unsigned DefDw   = 8;
    localparam int unsigned DefAccW = 24;
    localparam int unsigned DigitW  = 4;

    // Working width of sat_add; callers sign-extend into it and keep the low w bits.
    localparam int unsigned SatW = 64;

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StDrain,
        StCmp,
        StDone
    } state_e;

    // Adds two signed values and clips the result to [-(2^(w-1)), 2^(w-1)-1].
    // One extra bit of headroom makes the pre-clip sum exact.
    function automatic logic signed [SatW-1:0] sat_add(input logic signed [SatW-1:0] a,
                                                        input logic signed [SatW-1:0] b,
                                                        input int unsigned            w);
        logic signed [SatW:0] one;
        logic signed [SatW:0] sum;
        logic signed [SatW:0] hi;
        logic signed [SatW:0] lo;
        one = 1;
        sum = $signed({a[SatW-1], a}) + $signed({b[SatW-1], b});
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return sum[SatW-1:0];
    endfunction

endpackage

// File: rtl/ann_mac.sv
// Shared multiply-accumulate unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : add a_i*b_i into the accumulator this cycle
//   clr_i      : synchronously zero the accumulator (wins over en_i)
//   a_i, b_i   : signed operands
//   acc_o      : signed saturating accumulator
module ann_mac
    import ann_pkg::*;
#(
    parameter int unsigned DW    = DefDw,
    parameter int unsigned ACC_W = DefAccW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic signed [DW-1:0]    a_i,
    input  logic signed [DW-1:0]    b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [2*DW-1:0]  prod;
    logic signed [SatW-1:0]  prod_ext;
    logic signed [SatW-1:0]  acc_ext;
    logic signed [SatW-1:0]  sum_w;
    logic signed [ACC_W-1:0] acc_q;
    logic                    unused_sum_hi;

    always_comb begin
        prod     = a_i * b_i;
        prod_ext = $signed({{(SatW - 2 * DW){prod[2*DW-1]}}, prod});
        acc_ext  = $signed({{(SatW - ACC_W){acc_q[ACC_W-1]}}, acc_q});
        sum_w    = sat_add(acc_ext, prod_ext, ACC_W);
    end

    // After clipping, the bits above ACC_W only repeat the sign bit.
    assign unused_sum_hi = ^sum_w[SatW-1:ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_w[ACC_W-1:0];
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ann_layer_sequencer.sv
// Walks all output neurons through one shared MAC and reports the argmax.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin a classification (only honoured while idle)
//   feat_addr       : feature memory address (element index i)
//   feat_data       : feature, one cycle after feat_addr
//   wt_addr         : weight memory address (neuron*N_IN + i)
//   wt_data         : weight, one cycle after wt_addr
//   busy            : high whenever not idle
//   done            : one-cycle result-valid pulse
//   predicted_digit : argmax of the last completed run
//   max_score       : score of predicted_digit
module ann_layer_sequencer
    import ann_pkg::*;
#(
    parameter int unsigned N_IN  = 784,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned ACC_W = DefAccW,
    localparam int unsigned FAW  = $clog2(N_IN),
    localparam int unsigned WAW  = $clog2(N_OUT * N_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [FAW-1:0]          feat_addr,
    input  logic signed [DW-1:0]    feat_data,
    output logic [WAW-1:0]          wt_addr,
    input  logic signed [DW-1:0]    wt_data,
    output logic                    busy,
    output logic                    done,
    output logic [DigitW-1:0]       predicted_digit,
    output logic signed [ACC_W-1:0] max_score
);

    localparam logic [FAW-1:0]    LastI = FAW'(N_IN - 1);
    localparam logic [DigitW-1:0] LastN = DigitW'(N_OUT - 1);

    state_e                  state_q, state_d;
    logic [FAW-1:0]          feat_addr_q, feat_addr_d;
    logic [WAW-1:0]          wt_addr_q, wt_addr_d;
    logic [DigitW-1:0]       neuron_q, neuron_d;
    logic signed [ACC_W-1:0] best_q, best_d;
    logic [DigitW-1:0]       best_idx_q, best_idx_d;
    logic [DigitW-1:0]       pred_q, pred_d;
    logic signed [ACC_W-1:0] score_q, score_d;

    logic                    acc_en;
    logic                    acc_clr;
    logic signed [ACC_W-1:0] acc;

    ann_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (acc_en),
        .clr_i (acc_clr),
        .a_i   (feat_data),
        .b_i   (wt_data),
        .acc_o (acc)
    );

    // feat_addr_q doubles as the element counter i; the address registers are
    // loaded on the edge that enters each MAC cycle so they hold elsewhere.
    always_comb begin
        state_d     = state_q;
        feat_addr_d = feat_addr_q;
        wt_addr_d   = wt_addr_q;
        neuron_d    = neuron_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        pred_d      = pred_q;
        score_d     = score_q;
        acc_en      = 1'b0;
        acc_clr     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StMac;
                    feat_addr_d = '0;
                    wt_addr_d   = '0;
                    neuron_d    = '0;
                    acc_clr     = 1'b1;
                end
            end
            StMac: begin
                // Data seen at i is element i-1; at i=0 it is stale.
                acc_en = (feat_addr_q != '0);
                if (feat_addr_q == LastI) begin
                    state_d = StDrain;
                end else begin
                    feat_addr_d = feat_addr_q + FAW'(1);
                    wt_addr_d   = wt_addr_q + WAW'(1);
                end
            end
            StDrain: begin
                acc_en  = 1'b1;
                state_d = StCmp;
            end
            StCmp: begin
                acc_clr = 1'b1;
                // Strict compare keeps the lowest index on ties.
                if ((neuron_q == '0) || (acc > best_q)) begin
                    best_d     = acc;
                    best_idx_d = neuron_q;
                end
                if (neuron_q == LastN) begin
                    state_d = StDone;
                    pred_d  = best_idx_d;
                    score_d = best_d;
                end else begin
                    state_d     = StMac;
                    neuron_d    = neuron_q + DigitW'(1);
                    feat_addr_d = '0;
                    wt_addr_d   = wt_addr_q + WAW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            feat_addr_q <= '0;
            wt_addr_q   <= '0;
            neuron_q    <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            pred_q      <= '0;
            score_q     <= '0;
        end else begin
            state_q     <= state_d;
            feat_addr_q <= feat_addr_d;
            wt_addr_q   <= wt_addr_d;
            neuron_q    <= neuron_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            pred_q      <= pred_d;
            score_q     <= score_d;
        end
    end

    assign feat_addr       = feat_addr_q;
    assign wt_addr         = wt_addr_q;
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign predicted_digit = pred_q;
    assign max_score       = score_q;

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Bench for ann_layer_sequencer: two instances (24-bit and 16-bit scores) share
// stimulus; results are checked against a plain-arithmetic argmax model.
module tb_ann_layer_sequencer;

    localparam int NIn  = 4;
    localparam int NOut = 10;
    localparam int RunCycles = NOut * (NIn + 2) + 1;

    logic clk;
    logic rst_n;
    logic start;

    logic signed [7:0] feat_mem [NIn];
    logic signed [7:0] wt_mem   [NIn*NOut];

    logic [1:0]         fa_a, fa_b;
    logic [5:0]         wa_a, wa_b;
    logic signed [7:0]  fd_a, fd_b, wd_a, wd_b;
    logic               busy_a, busy_b, done_a, done_b;
    logic [3:0]         dig_a, dig_b;
    logic signed [23:0] score_a;
    logic signed [15:0] score_b;

    int n_vec;
    int n_err;
    int prev_dig_a, prev_sc_a, prev_dig_b, prev_sc_b;

    ann_layer_sequencer #(.N_IN(NIn), .N_OUT(NOut), .DW(8), .ACC_W(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .feat_addr(fa_a), .feat_data(fd_a), .wt_addr(wa_a), .wt_data(wd_a),
        .busy(busy_a), .done(done_a), .predicted_digit(dig_a), .max_score(score_a)
    );

    ann_layer_sequencer #(.N_IN(NIn), .N_OUT(NOut), .DW(8), .ACC_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start),
        .feat_addr(fa_b), .feat_data(fd_b), .wt_addr(wa_b), .wt_data(wd_b),
        .busy(busy_b), .done(done_b), .predicted_digit(dig_b), .max_score(score_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read memories, one cycle latency.
    always @(posedge clk) begin
        fd_a <= feat_mem[fa_a];
        wd_a <= wt_mem[wa_a];
        fd_b <= feat_mem[fa_b];
        wd_b <= wt_mem[wa_b];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Dot product per neuron with clipping after every addition, then argmax
    // with the lowest index kept on ties.
    task automatic model(input int w, output int dig, output int sc);
        int hi, lo, acc, best;
        hi   = (1 << (w - 1)) - 1;
        lo   = -(1 << (w - 1));
        best = 0;
        dig  = 0;
        for (int n = 0; n < NOut; n++) begin
            acc = 0;
            for (int i = 0; i < NIn; i++) begin
                acc = acc + int'(feat_mem[i]) * int'(wt_mem[n*NIn+i]);
                if (acc > hi) acc = hi;
                if (acc < lo) acc = lo;
            end
            if (n == 0 || acc > best) begin
                best = acc;
                dig  = n;
            end
        end
        sc = best;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy_a"}, 32'(busy_a), 0);
        chk({tag, "_busy_b"}, 32'(busy_b), 0);
        chk({tag, "_done_a"}, 32'(done_a), 0);
        chk({tag, "_dig_a"},  32'(dig_a), 0);
        chk({tag, "_score_a"}, score_a, 0);
        chk({tag, "_score_b"}, score_b, 0);
        chk({tag, "_faddr_a"}, 32'(fa_a), 0);
        chk({tag, "_waddr_a"}, 32'(wa_a), 0);
    endtask

    // Called at a negedge while idle; returns at the negedge of the cycle after
    // done, so a following call issues a back-to-back start.
    task automatic do_run(input bit hold, input string tag);
        int ea_d, ea_s, eb_d, eb_s, done_cyc;
        model(24, ea_d, ea_s);
        model(16, eb_d, eb_s);
        done_cyc = 0;
        start = 1'b1;
        for (int cyc = 1; cyc <= RunCycles + 40; cyc++) begin
            @(negedge clk);
            if (!hold && cyc == 1) start = 1'b0;
            if (cyc == 10) start = 1'b1;
            if (!hold && cyc == 11) start = 1'b0;
            if (cyc == 30) begin
                chk({tag, "_mid_busy"},  32'(busy_a), 1);
                chk({tag, "_mid_dig_a"}, 32'(dig_a), prev_dig_a);
                chk({tag, "_mid_sc_a"},  score_a, prev_sc_a);
                chk({tag, "_mid_dig_b"}, 32'(dig_b), prev_dig_b);
                chk({tag, "_mid_sc_b"},  score_b, prev_sc_b);
            end
            if (done_a || done_b) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, done_cyc, RunCycles);
        chk({tag, "_done_b"},  32'(done_b), 1);
        chk({tag, "_dig_a"},   32'(dig_a), ea_d);
        chk({tag, "_score_a"}, score_a, ea_s);
        chk({tag, "_dig_b"},   32'(dig_b), eb_d);
        chk({tag, "_score_b"}, score_b, eb_s);
        @(negedge clk);
        chk({tag, "_post_done"}, 32'({done_a, done_b}), 0);
        chk({tag, "_post_busy"}, 32'({busy_a, busy_b}), 0);
        prev_dig_a = ea_d;
        prev_sc_a  = ea_s;
        prev_dig_b = eb_d;
        prev_sc_b  = eb_s;
    endtask

    task automatic fill_random(input bit narrow);
        for (int i = 0; i < NIn; i++)
            feat_mem[i] = narrow ? 8'($signed($urandom_range(4)) - 2) : 8'($urandom);
        for (int i = 0; i < NIn * NOut; i++)
            wt_mem[i] = narrow ? 8'($signed($urandom_range(4)) - 2) : 8'($urandom);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        prev_dig_a = 0; prev_sc_a = 0; prev_dig_b = 0; prev_sc_b = 0;
        start = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < NIn; i++) feat_mem[i] = '0;
        for (int i = 0; i < NIn * NOut; i++) wt_mem[i] = '0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Ascending weights: scores 0,4,...,36.
        for (int i = 0; i < NIn; i++) feat_mem[i] = 8'sd1;
        for (int n = 0; n < NOut; n++)
            for (int i = 0; i < NIn; i++) wt_mem[n*NIn+i] = 8'(n);
        do_run(1'b0, "ascend");
        chk("ascend_const_dig", 32'(dig_a), 9);
        chk("ascend_const_sc", score_a, 36);

        // Only neuron 3 non-zero and negative: all others tie at 0.
        for (int i = 0; i < NIn * NOut; i++) wt_mem[i] = '0;
        for (int i = 0; i < NIn; i++) wt_mem[3*NIn+i] = -8'sd1;
        do_run(1'b0, "tie");
        chk("tie_const_dig", 32'(dig_a), 0);

        // Large products: 16-bit instance must clip at 32767.
        for (int i = 0; i < NIn; i++) feat_mem[i] = 8'sd127;
        for (int i = 0; i < NIn * NOut; i++) wt_mem[i] = 8'sd127;
        do_run(1'b0, "sat");
        chk("sat_const_sc_b", score_b, 32767);
        chk("sat_const_sc_a", score_a, 64516);

        // start held high for the whole run.
        fill_random(1'b0);
        do_run(1'b1, "hold");

        // Reset in the middle of a run.
        fill_random(1'b0);
        start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        prev_dig_a = 0; prev_sc_a = 0; prev_dig_b = 0; prev_sc_b = 0;
        @(negedge clk);
        do_run(1'b0, "after_reset");

        // Back-to-back random runs, some with small values to provoke ties.
        for (int r = 0; r < 6; r++) begin
            fill_random(r[0]);
            do_run(1'b0, $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ann_layer_sequencer.md
# ann_layer_sequencer

Sequences a single shared multiply-accumulate datapath across all output neurons of the classifier layer, replacing ten parallel neurons with one time-multiplexed MAC. On a start pulse it walks feature and weight memories, forms each neuron's dot product, tracks the running argmax, and reports the predicted digit and its score. It sits between the feature/weight storage and the digit-display logic.

## Interface
Parameters:
- N_IN, 784, inputs per neuron (≥2)
- N_OUT, 10, output neurons (≤16)
- DW, 8, signed feature/weight width
- ACC_W, 24, signed accumulator/score width (≥2*DW)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one classification, sampled in IDLE only
- feat_addr  out  clog2(N_IN)  feature memory read address
- feat_data  in  DW  signed feature, valid 1 cycle after feat_addr
- wt_addr  out  clog2(N_OUT*N_IN)  weight memory read address, = neuron*N_IN + i
- wt_data  in  DW  signed weight, valid 1 cycle after wt_addr
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, result valid
- predicted_digit  out  4  argmax index of last completed run
- max_score  out  ACC_W  signed score of predicted_digit

## Operation
- States: IDLE, MAC, DRAIN, CMP, DONE.
- IDLE: start=1 → MAC; neuron=0, i=0, acc=0. start=0 → stay.
- MAC: drive feat_addr=i, wt_addr=neuron*N_IN+i; from i≥1 accumulate feat_data*wt_data (element i-1). i=N_IN-1 → DRAIN.
- DRAIN: accumulate final product (element N_IN-1); → CMP.
- CMP: if neuron=0 or acc > best (signed, strict) → best=acc, best_idx=neuron. Clear acc. neuron=N_OUT-1 → DONE, else neuron+1, i=0 → MAC.
- DONE: predicted_digit=best_idx, max_score=best, done=1; → IDLE.
- Arithmetic: DW×DW signed product, 2*DW bits, sign-extended to ACC_W; accumulation saturates at ACC_W signed max/min (no wrap).
- Ties: lowest index wins (strict greater-than).
- start while busy: ignored, not queued.
- Addresses hold last value in IDLE/DRAIN/CMP/DONE; memories read-only, no enable port.

## Timing
- Reset: state IDLE, busy=0, done=0, predicted_digit=0, max_score=0, feat_addr=0, wt_addr=0, internal acc/best/counters 0.
- Start sampled at edge 0 → busy=1 from cycle 1; each neuron occupies N_IN+2 cycles (N_IN MAC, 1 DRAIN, 1 CMP).
- done high during cycle N_OUT*(N_IN+2)+1; busy falls the cycle after. Next start accepted in the cycle after done.
- predicted_digit/max_score change only on the edge entering DONE; stable otherwise, including during a subsequent run.
- rst_n low mid-run: immediate abort to reset values; no done pulse; previous result lost.
- Memory read latency fixed at 1 cycle; no back-pressure.

## Structure
- Package ann_pkg: state enum, ACC_W/DW defaults, sat_add function, N_OUT digit-width constant.
- One sub-module ann_mac: signed multiply, sign-extend, saturating accumulate, synchronous clear; sequencer holds FSM, counters, argmax registers.

## Test plan
- Bench N_IN=4, N_OUT=10: features all 1, weights for neuron n all n → scores 0,4,…,36; predicted_digit=9, max_score=36, done at cycle 61.
- Weights all 0 except neuron 3 = −1 → all others tie at 0; predicted_digit=0 (lowest tie), max_score=0.
- Features 127, weights 127, ACC_W=16 → per-neuron sum saturates to 32767, not wrap; predicted_digit=0.
- start held high through run and pulsed mid-run → exactly one done per 61-cycle run; no restart mid-run.
- rst_n asserted at cycle 20 → busy=0, outputs 0 same cycle; new start yields correct result, no stale accumulator.
- Back-to-back: start in cycle after done → second run's result replaces first only at its DONE edge.
